// File: rtl/decrypt_byte_packer.sv
// Packs a decrypted byte stream little-endian into 32-bit words and queues them
// in a small FIFO with a ready/valid word interface and a sticky overflow flag.
module decrypt_byte_packer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               din,
  input  logic                     din_v,
  input  logic                     flush,
  output logic [31:0]              dout,
  output logic [2:0]               dout_nbytes,
  output logic                     dout_v,
  input  logic                     dout_rdy,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [2:0]  nbytes;
    logic [31:0] data;
  } entry_t;

  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   part_q, part_d;
  logic [31:0]   word_c;
  logic [2:0]    nbytes_c;
  logic          push_c;

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_c;
  logic          full_c, pop_c, accept_c, drop_c;
  logic          ovf_q, ovf_d;
  entry_t        mem_q [DEPTH];

  // Packer: merge the incoming byte into its lane and decide whether a word closes.
  always_comb begin
    word_c   = {8'h00, part_q};
    nbytes_c = 3'(cnt_q) + 3'(din_v);
    cnt_d    = cnt_q;
    part_d   = part_q;
    if (din_v) begin
      case (cnt_q)
        2'd0:    word_c[7:0]   = din;
        2'd1:    word_c[15:8]  = din;
        2'd2:    word_c[23:16] = din;
        default: word_c[31:24] = din;
      endcase
    end
    push_c = (din_v && (cnt_q == 2'd3)) || (flush && (nbytes_c != 3'd0));
    if (push_c) begin
      cnt_d  = 2'd0;
      part_d = 24'h000000;
    end else if (din_v) begin
      cnt_d  = cnt_q + 2'd1;
      part_d = word_c[23:0];
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a full-time push needs.
  always_comb begin
    level_c  = wr_ptr_q - rd_ptr_q;
    full_c   = (level_c == LW'(DEPTH));
    pop_c    = (level_c != '0) && dout_rdy;
    accept_c = push_c && (!full_c || pop_c);
    drop_c   = push_c && full_c && !pop_c;
    wr_ptr_d = wr_ptr_q + LW'(accept_c);
    rd_ptr_d = rd_ptr_q + LW'(pop_c);
    ovf_d    = ovf_q | drop_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 2'd0;
      part_q   <= 24'h000000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      if (accept_c) begin
        mem_q[wr_ptr_q[AW-1:0]] <= '{nbytes: nbytes_c, data: word_c};
      end
    end
  end

  assign dout        = mem_q[rd_ptr_q[AW-1:0]].data;
  assign dout_nbytes = mem_q[rd_ptr_q[AW-1:0]].nbytes;
  assign dout_v      = (level_c != '0);
  assign level       = level_c;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_decrypt_byte_packer.sv
// Scoreboard bench for decrypt_byte_packer: stimulus pushes expected words,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_decrypt_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_v;
  logic        flush;
  logic [31:0] dout;
  logic [2:0]  dout_nbytes;
  logic        dout_v;
  logic        dout_rdy;
  logic        ovf;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;
  logic [34:0] sb [$];

  decrypt_byte_packer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_v(din_v), .flush(flush),
    .dout(dout), .dout_nbytes(dout_nbytes), .dout_v(dout_v),
    .dout_rdy(dout_rdy), .ovf(ovf), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: a word transfers on the coming edge whenever dout_v & dout_rdy.
  always @(negedge clk) begin
    if (rst === 1'b1 && dout_v === 1'b1 && dout_rdy === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got %h/%0d want none", dout, dout_nbytes);
      end else begin
        logic [34:0] e;
        e = sb.pop_front();
        if ({dout_nbytes, dout} !== e) begin
          bad++;
          $display("FAIL mon_word: got %0d/%h want %0d/%h", dout_nbytes, dout, e[34:32], e[31:0]);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic rdy);
    din_v = v; din = d; flush = f; dout_rdy = rdy;
    @(posedge clk); #1;
    din_v = 1'b0; flush = 1'b0;
  endtask

  task automatic expect_word(input logic [2:0] n, input logic [31:0] w);
    sb.push_back({n, w});
  endtask

  task automatic drain();
    dout_rdy = 1'b1;
    for (int i = 0; i < 20 && dout_v; i++) begin
      @(posedge clk); #1;
    end
    dout_rdy = 1'b0;
    chk("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    rst = 1'b0; din = 8'h00; din_v = 1'b0; flush = 1'b0; dout_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_nbytes", 32'(dout_nbytes), 32'd0);
    chk("rst_dout_v", 32'(dout_v), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b1;

    // Four bytes form one full word
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
    expect_word(3'd4, 32'h44332211);
    chk("w1_dout", dout, 32'h44332211);
    chk("w1_nbytes", 32'(dout_nbytes), 32'd4);
    chk("w1_dout_v", 32'(dout_v), 32'd1);
    chk("w1_level", 32'(level), 32'd1);
    chk("w1_ovf", 32'(ovf), 32'd0);

    // Flush a two-byte partial, then an empty flush
    step(1, 8'hAA, 0, 0); step(1, 8'hBB, 0, 0); step(0, 8'h00, 1, 0);
    expect_word(3'd2, 32'h0000BBAA);
    chk("flush_level", 32'(level), 32'd2);
    step(0, 8'h00, 1, 0);
    chk("flush0_level", 32'(level), 32'd2);
    chk("hold_dout", dout, 32'h44332211);
    drain();

    // Flush together with the fourth byte
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(1, 8'h03, 0, 0); step(1, 8'h04, 1, 0);
    expect_word(3'd4, 32'h04030201);
    chk("fl4_level", 32'(level), 32'd1);
    chk("fl4_dout", dout, 32'h04030201);
    chk("fl4_nbytes", 32'(dout_nbytes), 32'd4);
    drain();

    // Overflow: 20 bytes into a 4-deep FIFO, fifth word lost
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 18) chk("ovf_before", 32'(ovf), 32'd0);
    end
    expect_word(3'd4, 32'h03020100);
    expect_word(3'd4, 32'h07060504);
    expect_word(3'd4, 32'h0B0A0908);
    expect_word(3'd4, 32'h0F0E0D0C);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_head", dout, 32'h03020100);
    drain();
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with a pop and a push in the same cycle
    rst = 1'b0; #1; rst = 1'b1;
    chk("clr_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + 8'(i)), 0, 0);
    expect_word(3'd4, 32'h23222120);
    expect_word(3'd4, 32'h27262524);
    expect_word(3'd4, 32'h2B2A2928);
    expect_word(3'd4, 32'h2F2E2D2C);
    chk("full_level", 32'(level), 32'd4);
    step(1, 8'h30, 0, 0); step(1, 8'h31, 0, 0); step(1, 8'h32, 0, 0);
    expect_word(3'd4, 32'h33323130);
    step(1, 8'h33, 0, 1);
    dout_rdy = 1'b0;
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_ovf", 32'(ovf), 32'd0);
    chk("fullpp_head", dout, 32'h27262524);
    drain();

    // Asynchronous reset mid-word with words queued
    for (int i = 0; i < 11; i++) step(1, 8'(8'h40 + 8'(i)), 0, 0);
    chk("pre_rst_level", 32'(level), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_dout_v", 32'(dout_v), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1, 8'h55, 0, 0); step(1, 8'h66, 0, 0); step(1, 8'h77, 0, 0); step(1, 8'h88, 0, 0);
    expect_word(3'd4, 32'h88776655);
    chk("post_rst_dout", dout, 32'h88776655);
    chk("post_rst_nbytes", 32'(dout_nbytes), 32'd4);
    chk("post_rst_level", 32'(level), 32'd1);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decrypt_byte_packer.md
# decrypt_byte_packer

Output stage placed directly downstream of the decryption unit. It collects the decrypted byte stream (8-bit data plus valid strobe, no backpressure available) and packs it little-endian into 32-bit words. Completed words go into a small FIFO that drives a ready/valid word interface toward the system bus side. Partial words can be closed by a flush. Loss caused by a full FIFO is reported, never stalled.

## Interface

Parameters:
- DEPTH, default 4: FIFO depth in words. Must be a power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din  in  8  decrypted byte from the decryption unit's data output.
- din_v  in  1  byte valid; din is sampled on every edge where din_v = 1.
- flush  in  1  close the current partial word (single-cycle pulse or level; evaluated every edge).
- dout  out  32  head-of-FIFO word; byte 0 in [7:0].
- dout_nbytes  out  3  number of valid bytes in dout, 1..4.
- dout_v  out  1  FIFO not empty.
- dout_rdy  in  1  consumer ready; a word transfers on an edge where dout_v & dout_rdy.
- ovf  out  1  sticky overflow flag; cleared only by reset.
- level  out  $clog2(DEPTH)+1  number of words currently in the FIFO.

## Operation

- Packer holds a byte count `cnt` (0..3) and a 24-bit partial word.
- On din_v, din is placed at byte lane `cnt`.
- Word push is generated combinationally in the same cycle as the byte that completes it. Conditions:
  - din_v with cnt = 3: push a 4-byte word with nbytes = 4.
  - flush with cnt > 0 (after including a same-cycle din_v byte): push a partial word. Unused upper lanes are 0; nbytes equals the byte count including that byte.
  - flush with cnt = 0 and no din_v: no effect.
  - flush together with the 4th byte: exactly one word is pushed, with nbytes = 4.
- After any push attempt, cnt returns to 0.
- FIFO stores {nbytes, word}. It uses circular read/write pointers that carry one extra wrap bit.
  - full = level == DEPTH; empty = level == 0.
- Push when full and no pop in the same cycle: the word is dropped, ovf is set to 1, and the packer still clears. The stored data is unchanged.
- Push when full with a pop in the same cycle: the push is accepted, no ovf, and level stays DEPTH.
- Simultaneous push and pop at any level: level is unchanged and FIFO order is preserved.
- Pop when empty cannot occur, because dout_v = 0 gates it.
- dout and dout_nbytes must stay stable while dout_v = 1 and dout_rdy = 0.

## Timing

- Reset values, held while rst = 0:
  - cnt = 0, partial word = 0, pointers = 0, storage = 0.
  - dout = 0, dout_nbytes = 0, dout_v = 0, level = 0, ovf = 0.
- Reset asserted mid-word or with words queued: all state clears immediately (asynchronously). The partial byte and queued words are discarded, and no ovf is set.
- Latency when the FIFO is empty: if the word-completing byte (or flush) is sampled at edge N, dout/dout_v are valid right after edge N. That is one cycle after the byte is presented.
- Pop at edge N: the next entry (or dout_v = 0) is visible after edge N.
- Throughput: one byte per cycle in, and one word per cycle out.
- Every byte sampled is either delivered or counted toward ovf; there is no silent loss.
- ovf rises the cycle after the first dropped push and remains 1.

## Test plan

- Reset, then din = 0x11, 0x22, 0x33, 0x44 on consecutive cycles with dout_rdy = 0 -> after the 4th edge: dout = 0x44332211, dout_nbytes = 4, dout_v = 1, level = 1, ovf = 0.
- Bytes 0xAA, 0xBB, then flush alone -> dout = 0x0000BBAA, nbytes = 2. Then flush again with cnt = 0 -> level unchanged.
- flush asserted in the same cycle as the 4th byte 0x01..0x04 -> one word 0x04030201, nbytes = 4, level increases by 1.
- DEPTH = 4, dout_rdy = 0, 20 bytes 0x00..0x13 -> level = 4 and ovf = 1 after byte 0x13. Then draining with rdy = 1 yields 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order; 0x13121110 is lost.
- FIFO full (level 4), dout_rdy = 1 and a word completing in the same cycle -> head pops, new word accepted, level = 4, ovf stays 0.
- Reset pulsed after 3 bytes with 2 words queued -> immediately dout_v = 0, level = 0, ovf = 0. The next bytes 0x55, 0x66, 0x77, 0x88 give dout = 0x88776655, nbytes = 4.
